// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958) transmitter: buffers one stereo pair, frames it into
// B/M/W-preambled 32-slot subframes and biphase-mark encodes them onto o_spdif.
//
// state | meaning
// IDLE  | line parked at 0, waiting for the first accepted pair
// PRE   | 8 preamble half-bits (slots 0-3)
// DATA  | 56 BMC half-bits (slots 4-31)
module spdif_tx #(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = 8
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [23:0] i_left,
    input  logic [23:0] i_right,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_cs_bit,
    output logic [7:0]  o_cs_index,
    output logic        o_spdif,
    output logic        o_underrun
);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] PAT_B = 8'b11101000;
    localparam logic [7:0] PAT_M = 8'b11100010;
    localparam logic [7:0] PAT_W = 8'b11100100;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       hb_q, hb_d;
    logic             sub_q, sub_d;
    logic [47:0]      hold_q, hold_d;
    logic             ready_q, ready_d;
    logic [47:0]      frm_q, frm_d;
    logic             vflag_q, vflag_d;
    logic             inv_q, inv_d;
    logic             bit_q, bit_d;
    logic             par_q, par_d;
    logic             line_q, line_d;
    logic [7:0]       cs_q, cs_d;
    logic             under_q, under_d;

    logic        tick;
    logic        hs;
    logic        ld;
    logic [4:0]  slot;
    logic [7:0]  pat;
    logic        pre_inv;
    logic [23:0] sample;
    logic        data_bit;

    always_comb begin
        tick    = (state_q != IDLE) && (div_q == DIV_LAST);
        hs      = i_valid && ready_q;
        ld      = tick && (state_q == PRE) && (hb_q == 6'd0) && !sub_q;
        slot    = hb_q[5:1];
        pat     = sub_q ? PAT_W : ((cs_q == 8'd0) ? PAT_B : PAT_M);
        pre_inv = (hb_q == 6'd0) ? line_q : inv_q;
        sample  = sub_q ? frm_q[23:0] : frm_q[47:24];

        if (slot < 5'd24) begin
            data_bit = sample[slot];
        end else begin
            case (slot)
                5'd24:   data_bit = vflag_q;
                5'd25:   data_bit = 1'b0;
                5'd26:   data_bit = i_cs_bit;
                default: data_bit = par_q;
            endcase
        end

        state_d = state_q;
        hb_d    = hb_q;
        sub_d   = sub_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        frm_d   = frm_q;
        vflag_d = vflag_q;
        inv_d   = inv_q;
        bit_d   = bit_q;
        par_d   = par_q;
        line_d  = line_q;
        cs_d    = cs_q;
        under_d = 1'b0;

        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                if (tick) begin
                    // Pattern is relative to the level left by the previous subframe.
                    line_d = pat[~hb_q[2:0]] ^ pre_inv;
                    par_d  = 1'b0;
                    if (hb_q == 6'd0) begin
                        inv_d = line_q;
                    end
                    if (hb_q == 6'd7) begin
                        state_d = DATA;
                        hb_d    = 6'd0;
                    end else begin
                        hb_d = hb_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (!hb_q[0]) begin
                        line_d = ~line_q;
                        bit_d  = data_bit;
                        if (slot != 5'd27) begin
                            par_d = par_q ^ data_bit;
                        end
                    end else begin
                        line_d = line_q ^ bit_q;
                    end
                    if (hb_q == 6'd55) begin
                        state_d = PRE;
                        hb_d    = 6'd0;
                        sub_d   = ~sub_q;
                        if (sub_q) begin
                            cs_d = (cs_q == 8'd191) ? 8'd0 : cs_q + 8'd1;
                        end
                    end else begin
                        hb_d = hb_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start drains the holding register; an empty one sends silence with V=1.
        if (ld) begin
            ready_d = 1'b1;
            if (ready_q) begin
                frm_d   = '0;
                vflag_d = 1'b1;
                under_d = 1'b1;
            end else begin
                frm_d   = hold_q;
                vflag_d = 1'b0;
            end
        end
        if (hs) begin
            hold_d  = {i_left, i_right};
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            hb_q    <= '0;
            sub_q   <= 1'b0;
            hold_q  <= '0;
            ready_q <= 1'b1;
            frm_q   <= '0;
            vflag_q <= 1'b0;
            inv_q   <= 1'b0;
            bit_q   <= 1'b0;
            par_q   <= 1'b0;
            line_q  <= 1'b0;
            cs_q    <= '0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hb_q    <= hb_d;
            sub_q   <= sub_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
            frm_q   <= frm_d;
            vflag_q <= vflag_d;
            inv_q   <= inv_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            line_q  <= line_d;
            cs_q    <= cs_d;
            under_q <= under_d;
        end
    end

    assign o_spdif    = line_q;
    assign o_ready    = ready_q;
    assign o_cs_index = cs_q;
    assign o_underrun = under_q;

endmodule
